// File: rtl/hd_pkg.sv
// Shared types and helpers for the feature-serial hyperdimensional encoder:
// FSM state type, chunk-count helpers and the saturating lane adder.
package hd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } hd_enc_state_t;

    typedef struct packed {
        logic [63:0] sum;
        logic        ovf;
    } sat_res_t;

    function automatic int chunk_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    localparam int NCHUNK  = 512 / 64;
    localparam int CHUNK_W = chunk_width(NCHUNK);

    // Width-generic: acc arrives sign-extended to 64 bits, and the result is
    // clamped to the signed range of 'width' bits (width must be below 63).
    function automatic sat_res_t sat_add(input logic signed [63:0] acc,
                                         input logic [63:0]        delta,
                                         input logic               neg,
                                         input int                 width);
        logic signed [65:0] full;
        logic signed [65:0] max_v;
        logic signed [65:0] min_v;
        sat_res_t           r;
        max_v = (66'sd1 <<< (width - 1)) - 66'sd1;
        min_v = -(66'sd1 <<< (width - 1));
        if (neg)
            full = 66'(acc) - $signed({2'b00, delta});
        else
            full = 66'(acc) + $signed({2'b00, delta});
        r.ovf = 1'b1;
        if (full > max_v)
            r.sum = max_v[63:0];
        else if (full < min_v)
            r.sum = min_v[63:0];
        else begin
            r.sum = full[63:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/hd_lane_acc.sv
// One lane of the encoder: a signed saturating accumulator that adds or
// subtracts an unsigned feature each enabled cycle.
module hd_lane_acc
    import hd_pkg::*;
#(
    parameter int FTWIDTH   = 8,
    parameter int DIM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 neg,
    input  logic [FTWIDTH-1:0]   delta,
    output logic [DIM_WIDTH-1:0] acc,
    output logic                 ovf
);

    sat_res_t res;
    logic     unused_sum_hi;

    always_comb begin
        res = sat_add(64'(signed'(acc)), 64'(delta), neg, DIM_WIDTH);
    end

    assign ovf           = en & res.ovf;
    assign unused_sum_hi = ^res.sum[63:DIM_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= res.sum[DIM_WIDTH-1:0];
    end

endmodule

// File: rtl/hd_stream_encoder.sv
// Feature-serial hyperdimensional encoder: accumulates N_FEAT projected features
// per chunk across LANES lanes and streams D_TOTAL/LANES chunks downstream.
module hd_stream_encoder
    import hd_pkg::*;
#(
    parameter int LANES     = 64,
    parameter int N_FEAT    = 64,
    parameter int FTWIDTH   = 8,
    parameter int DIM_WIDTH = 16,
    parameter int D_TOTAL   = 512,
    localparam int NUM_CHUNKS = D_TOTAL / LANES,
    localparam int CHUNK_BITS = chunk_width(NUM_CHUNKS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       bin_mode,
    input  logic                       feat_valid,
    output logic                       feat_ready,
    input  logic [FTWIDTH-1:0]         feat_data,
    input  logic [LANES-1:0]           proj_bits,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*DIM_WIDTH-1:0] out_data,
    output logic [CHUNK_BITS-1:0]      out_chunk,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       sat
);

    localparam int FEAT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    if (D_TOTAL % LANES != 0) begin : g_bad_dtotal
        $error("hd_stream_encoder: D_TOTAL must be a multiple of LANES");
    end

    hd_enc_state_t     state;
    logic [FEAT_W-1:0] feat_cnt;
    logic [CHUNK_BITS-1:0] chunk;
    logic              bin_latch;
    logic [LANES-1:0]  lane_ovf;

    logic feat_fire;
    logic out_fire;
    logic last_chunk;
    logic last_feat;
    logic acc_clear;

    assign feat_fire  = (state == ACCUM) && feat_valid;
    assign out_fire   = (state == EMIT) && out_ready;
    assign last_chunk = (chunk == CHUNK_BITS'(NUM_CHUNKS - 1));
    assign last_feat  = (feat_cnt == FEAT_W'(N_FEAT - 1));
    assign acc_clear  = ((state == IDLE) && start) || (out_fire && !last_chunk);

    assign feat_ready = (state == ACCUM);
    assign out_valid  = (state == EMIT);
    assign busy       = (state != IDLE);
    assign out_chunk  = chunk;
    assign out_last   = out_valid && last_chunk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            feat_cnt  <= '0;
            chunk     <= '0;
            bin_latch <= 1'b0;
            done      <= 1'b0;
            sat       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ACCUM;
                        feat_cnt  <= '0;
                        chunk     <= '0;
                        bin_latch <= bin_mode;
                        sat       <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (feat_valid) begin
                        feat_cnt <= feat_cnt + 1'b1;
                        if (|lane_ovf)
                            sat <= 1'b1;
                        if (last_feat) begin
                            state    <= EMIT;
                            feat_cnt <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (last_chunk) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            chunk    <= chunk + 1'b1;
                            feat_cnt <= '0;
                            state    <= ACCUM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accumulators survive into IDLE so the last chunk stays readable.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DIM_WIDTH-1:0] lane_acc;

        hd_lane_acc #(
            .FTWIDTH  (FTWIDTH),
            .DIM_WIDTH(DIM_WIDTH)
        ) u_acc (
            .clk  (clk),
            .reset(reset),
            .clear(acc_clear),
            .en   (feat_fire),
            .neg  (!proj_bits[i]),
            .delta(feat_data),
            .acc  (lane_acc),
            .ovf  (lane_ovf[i])
        );

        assign out_data[i*DIM_WIDTH +: DIM_WIDTH] =
            bin_latch ? {{(DIM_WIDTH-1){1'b0}}, !lane_acc[DIM_WIDTH-1]} : lane_acc;
    end

endmodule

// File: doc/hd_stream_encoder.md
# hd_stream_encoder

Parametrised, feature-serial hyperdimensional encoder. It is the successor to the fixed 64-lane encoding block. It takes one feature per handshake, along with that feature's LANES-wide bipolar projection row, and accumulates signed sums into LANES lane accumulators. It emits the hypervector chunk by chunk over a valid/ready output until D_TOTAL dimensions are produced. It sits between the feature/projection fetch logic and the class-similarity stage, and adds a start/done protocol, backpressure, saturation and a binarised output mode.

## Interface
- LANES, 64, dimensions computed per chunk (lane count)
- N_FEAT, 64, features per sample
- FTWIDTH, 8, unsigned feature width
- DIM_WIDTH, 16, signed accumulator/output width per lane
- D_TOTAL, 512, hypervector dimension; must be a multiple of LANES (elaboration error otherwise)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a sample; honoured only in IDLE
- bin_mode  in  1  sampled on accepted start; 1 = binarised output
- feat_valid  in  1  feature beat valid
- feat_ready  out  1  block accepts a feature beat
- feat_data  in  FTWIDTH  unsigned feature value
- proj_bits  in  LANES  projection row; bit i=1 adds to lane i, 0 subtracts from lane i
- out_valid  out  1  chunk valid
- out_ready  in  1  downstream accepts chunk
- out_data  out  LANES×DIM_WIDTH  lane results, lane i at index i
- out_chunk  out  $clog2(D_TOTAL/LANES) (min 1)  chunk index of out_data
- out_last  out  1  out_data is the final chunk of the sample
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after the final chunk handshake
- sat  out  1  sticky: some lane saturated during the current sample

## Operation
- FSM states: IDLE, ACCUM, EMIT.
  - IDLE: if start is high, clear accumulators, set chunk=0 and feat_cnt=0, clear sat, latch bin_mode, go to ACCUM.
  - ACCUM: feat_ready=1. On each feat_valid&&feat_ready, lane i gets acc[i] ± zero-extended feat_data, and feat_cnt increments. The beat with feat_cnt==N_FEAT-1 moves to EMIT.
  - EMIT: feat_ready=0, out_valid=1. On handshake, if chunk==D_TOTAL/LANES-1: pulse done and go to IDLE. Otherwise increment chunk, clear accumulators and feat_cnt, and go to ACCUM.
- Arithmetic: signed DIM_WIDTH, saturating at +2^(DIM_WIDTH-1)-1 and -2^(DIM_WIDTH-1). Any clamp sets sat. Features are always non-negative.
- out_data in normal mode is acc[i].
- out_data in bin_mode is {DIM_WIDTH-1 zeros, acc[i]>=0}.
- out_data, out_chunk and out_last hold stable while out_valid && !out_ready.
- start is ignored outside IDLE. feat_valid is ignored outside ACCUM, and no beat is consumed.
- out_data retains the last accumulator values in IDLE. sat holds until the next accepted start.

## Timing
- Reset values: feat_ready=0, out_valid=0, out_data=0, out_chunk=0, out_last=0, busy=0, done=0, sat=0, state=IDLE.
- Reset asserted mid-sample aborts immediately and produces no done.
- Start accepted at edge t: busy=1 and feat_ready=1 from t+1.
- The N_FEAT-th feature handshake at edge t gives out_valid=1 from t+1 with the final sums.
- Output handshake at edge t:
  - non-final chunk: feat_ready=1 from t+1;
  - final chunk: done=1 and busy=0 during cycle t+1 only.
- Minimum throughput is N_FEAT+1 cycles per chunk. Full sample: (D_TOTAL/LANES)·(N_FEAT+1)+1 cycles from start to done.
- Back-to-back: start may be high in the done cycle and is accepted (state is IDLE).

## Structure
- Package hd_pkg holds:
  - the state enum hd_enc_state_t (IDLE, ACCUM, EMIT);
  - function sat_add(acc, delta, neg), which returns the clamped sum and an overflow flag;
  - localparams NCHUNK=D_TOTAL/LANES and CHUNK_W.
- One sub-module, hd_lane_acc: a single lane's saturating accumulator with clear/enable/sign inputs and an overflow output, generated LANES times.

## Test plan
- Parameters LANES=4, N_FEAT=4, D_TOTAL=8: start, four beats of feat_data=10 with proj_bits=4'b1111 -> chunk 0 out_data={40,40,40,40}, out_last=0; feed the same again -> chunk 1 equal, out_last=1, done pulse one cycle after the handshake.
- Mixed signs, same config: proj_bits=4'b0101 with features 3,5,7,9 -> lanes 0,2=24, lanes 1,3=-24. With bin_mode=1 -> {1,0,1,0} in lane order 0..3.
- Saturation: DIM_WIDTH=8, N_FEAT=4, features 100 with proj_bits all 1 -> lanes=127, sat=1. All 0 -> lanes=-128.
- Backpressure: out_ready low 5 cycles in EMIT -> out_data/out_chunk stable, feat_ready=0, feat_valid beats not consumed.
- Reset low mid-ACCUM (after 2 beats) -> all outputs at reset values next cycle, no done. A new start then yields correct sums.
- Default parameters: 8 chunks × 64 features=1, projections all 1 -> every lane 64 in every chunk, done exactly 8·65+1 cycles after start.
